// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency memory between instruction
//               fetch and the data stage, one outstanding access at a time.
//               Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    // data stage port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    // memory port
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_lat_cnt;
    logic               r_own;      // 0 = IF, 1 = data stage

    logic w_idle;
    logic w_force_if;
    logic w_d_win;
    logic w_if_win;
    logic w_rd_grant;
    logic w_ret;

    generate
        if (MEM_LAT < 1) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
        if (STARVE_MAX < 1) begin : g_starve_check
            $error("mem_port_arbiter: STARVE_MAX must be >= 1");
        end
    endgenerate

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);

    logic [c_STV_W-1:0] r_starve_cnt;

    // Counts consecutive cycles IF has been left waiting, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (r_starve_cnt != c_STV_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + c_STV_W'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign w_force_if = if_req && (r_starve_cnt == c_STV_W'(STARVE_MAX));
`else
    assign w_force_if = 1'b0;
`endif

    // Arbitration: only in IDLE; data stage is older so it wins unless IF is starved.
    always_comb begin
        w_idle     = (r_state == c_ST_IDLE) && !reset;
        w_d_win    = w_idle && d_req && !w_force_if;
        w_if_win   = w_idle && if_req && (!d_req || w_force_if);
        w_rd_grant = w_if_win || (w_d_win && !d_we);
        w_ret      = (r_state == c_ST_WAIT) && (r_lat_cnt == c_CNT_W'(1)) && !reset;
    end

    always_comb begin
        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_en    = w_if_win || w_d_win;
        mem_we    = w_d_win && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_we ? d_be : {c_BE_W{1'b1}};
        end else if (w_if_win) begin
            mem_addr  = if_addr;
            mem_be    = {c_BE_W{1'b1}};
        end
    end

    // Read data is a straight pass-through, gated to the owner's single rvalid cycle.
    always_comb begin
        if_rvalid = w_ret && !r_own;
        d_rvalid  = w_ret && r_own;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;
        busy      = (r_state == c_ST_WAIT) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_lat_cnt <= '0;
            r_own     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rd_grant) begin
                        r_own     <= w_d_win;
                        r_lat_cnt <= c_CNT_W'(MEM_LAT);
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - c_CNT_W'(1);
                    if (r_lat_cnt == c_CNT_W'(1)) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter with a small
//               byte-enabled memory model; follows ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_mem_port_arbiter;

    localparam int c_ADDR_W  = 9;
    localparam int c_DATA_W  = 32;
    localparam int c_MEM_LAT = 2;
    localparam int c_STARVE  = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W    (c_ADDR_W),
        .DATA_W    (c_DATA_W),
        .MEM_LAT   (c_MEM_LAT),
        .STARVE_MAX(c_STARVE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word a initially holds 0x1000_0000 + a; stores overlay per byte.
    bit [31:0] r_wmask [0:511];
    bit [31:0] r_wdat  [0:511];
    bit [31:0] r_pipe  [0:c_MEM_LAT-1];
    logic [31:0] w_rd_word;
    logic [31:0] w_be_mask;

    always_comb begin
        w_rd_word = ((32'h1000_0000 + 32'(mem_addr)) & ~r_wmask[mem_addr])
                  | (r_wdat[mem_addr] & r_wmask[mem_addr]);
        w_be_mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
    end

    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            r_wmask[mem_addr] <= r_wmask[mem_addr] | w_be_mask;
            r_wdat[mem_addr]  <= (r_wdat[mem_addr] & ~w_be_mask) | (mem_wdata & w_be_mask);
        end
        r_pipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0) ? w_rd_word : 32'hDEAD_BEEF;
        for (int k = 1; k < c_MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
    assign mem_rdata = r_pipe[c_MEM_LAT-1];

    // Scoreboard
    typedef struct {
        int          cyc;
        bit          is_d;
        bit          we;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] data;
    } rv_t;

    gnt_t q_gnt[$];
    rv_t  q_rv[$];
    int   q_busy[$];

    int n_cmp = 0;
    int n_bad = 0;

    gnt_t m_g;
    rv_t  m_r;
    int   m_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name, input int want_cyc);
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cycle %0d: event expected at cycle %0d", name, cyc, want_cyc);
    endtask

    task automatic exp_read(input int c, input bit is_d, input logic [8:0] a, input logic [31:0] data);
        q_gnt.push_back('{c, is_d, 1'b0, a, 4'hF, 32'h0});
        for (int k = 1; k <= c_MEM_LAT; k++) q_busy.push_back(c + k);
        q_rv.push_back('{c + c_MEM_LAT, is_d, data});
    endtask

    task automatic exp_store(input int c, input logic [8:0] a, input logic [3:0] be, input logic [31:0] wd);
        q_gnt.push_back('{c, 1'b1, 1'b1, a, be, wd});
    endtask

    // Monitor: samples on the falling edge, pops on every DUT output event.
    always @(negedge clk) begin
        while (q_gnt.size() > 0 && q_gnt[0].cyc < cyc) begin
            m_g = q_gnt.pop_front();
            flag("gnt_missing", m_g.cyc);
        end
        while (q_rv.size() > 0 && q_rv[0].cyc < cyc) begin
            m_r = q_rv.pop_front();
            flag("rvalid_missing", m_r.cyc);
        end
        while (q_busy.size() > 0 && q_busy[0] < cyc) begin
            m_b = q_busy.pop_front();
            flag("busy_missing", m_b);
        end

        if (if_gnt === 1'b1 || d_gnt === 1'b1) begin
            if (q_gnt.size() == 0) begin
                flag("gnt_unexpected", -1);
            end else begin
                m_g = q_gnt.pop_front();
                chk("gnt_cycle", 64'(cyc), 64'(m_g.cyc));
                chk("gnt_owner", {if_gnt, d_gnt}, m_g.is_d ? 2'b01 : 2'b10);
                chk("mem_en", mem_en, 1'b1);
                chk("mem_we", mem_we, m_g.we);
                chk("mem_addr", mem_addr, m_g.addr);
                chk("mem_be", mem_be, m_g.be);
                if (m_g.we) chk("mem_wdata", mem_wdata, m_g.wdata);
            end
        end else if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0) begin
            flag("mem_strobe_without_gnt", -1);
        end

        if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
            if (q_rv.size() == 0) begin
                flag("rvalid_unexpected", -1);
            end else begin
                m_r = q_rv.pop_front();
                chk("rv_cycle", 64'(cyc), 64'(m_r.cyc));
                chk("rv_owner", {if_rvalid, d_rvalid}, m_r.is_d ? 2'b01 : 2'b10);
                chk("rv_data", m_r.is_d ? d_rdata : if_rdata, m_r.data);
                chk("rv_other_zero", m_r.is_d ? if_rdata : d_rdata, 32'h0);
            end
        end else begin
            chk("if_rdata_idle", if_rdata, 32'h0);
            chk("d_rdata_idle", d_rdata, 32'h0);
        end

        if (busy === 1'b1) begin
            if (q_busy.size() == 0) begin
                flag("busy_unexpected", -1);
            end else begin
                m_b = q_busy.pop_front();
                chk("busy_cycle", 64'(cyc), 64'(m_b));
            end
        end else if (busy !== 1'b0) begin
            chk("busy_known", busy, 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_D_RUN = c_STARVE;
`else
    localparam int c_D_RUN = 8;
`endif

    int t;

    initial begin
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 9'h030;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 9'h020;
        d_wdata = 32'h0;
        d_be    = 4'hF;

        // Reset with both requesting: nothing may fire, then data wins first.
        step();
        step();
        reset = 1'b0;
        t = cyc;
        exp_read(t, 1'b1, 9'h020, 32'h1000_0020);
        exp_read(t + 3, 1'b0, 9'h030, 32'h1000_0030);
        step();
        d_req = 1'b0;
        idle(3);
        if_req = 1'b0;
        idle(4);

        // Single IF read.
        if_req  = 1'b1;
        if_addr = 9'h010;
        t = cyc;
        exp_read(t, 1'b0, 9'h010, 32'h1000_0010);
        step();
        if_req = 1'b0;
        idle(4);

        // Store with IF waiting: IF granted the very next cycle.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 9'h004;
        d_be    = 4'b0011;
        d_wdata = 32'hAABB_CCDD;
        if_req  = 1'b1;
        if_addr = 9'h011;
        t = cyc;
        exp_store(t, 9'h004, 4'b0011, 32'hAABB_CCDD);
        exp_read(t + 1, 1'b0, 9'h011, 32'h1000_0011);
        step();
        d_req = 1'b0;
        step();
        if_req = 1'b0;
        idle(4);

        // Load back the partially written word.
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 9'h004;
        d_be   = 4'hF;
        t = cyc;
        exp_read(t, 1'b1, 9'h004, 32'h1000_CCDD);
        step();
        d_req = 1'b0;
        idle(4);

        // Back-to-back stores against a waiting IF.
        if_req  = 1'b1;
        if_addr = 9'h012;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        for (int i = 0; i < c_D_RUN; i++) begin
            d_addr  = 9'h040 + 9'(i);
            d_wdata = 32'h5000_0000 + 32'(i);
            exp_store(cyc, d_addr, 4'hF, d_wdata);
            step();
        end
`ifdef ARB_STARVE_GUARD_EN
        d_addr  = 9'h040 + 9'(c_D_RUN);
        d_wdata = 32'h5000_0000 + 32'(c_D_RUN);
        t = cyc;
        exp_read(t, 1'b0, 9'h012, 32'h1000_0012);
        exp_store(t + c_MEM_LAT + 1, d_addr, 4'hF, d_wdata);
        step();
        if_req = 1'b0;
        idle(c_MEM_LAT);
        d_req = 1'b0;
        idle(3);
`else
        d_req = 1'b0;
        t = cyc;
        exp_read(t, 1'b0, 9'h012, 32'h1000_0012);
        step();
        if_req = 1'b0;
        idle(4);
`endif

        // Reset during an IF read: the read is abandoned, arbiter free immediately.
        if_req  = 1'b1;
        if_addr = 9'h013;
        t = cyc;
        q_gnt.push_back('{t, 1'b0, 1'b0, 9'h013, 4'hF, 32'h0});
        step();
        if_req = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 9'h020;
        exp_read(cyc, 1'b1, 9'h020, 32'h1000_0020);
        step();
        d_req = 1'b0;
        idle(5);

        chk("gnt_queue_drained", 64'(q_gnt.size()), 64'd0);
        chk("rv_queue_drained", 64'(q_rv.size()), 64'd0);
        chk("busy_queue_drained", 64'(q_busy.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
